// File: rtl/dsp_pkg.sv
// Shared constants and helpers for the dsp_mac_pipe slice: OPMODE bit positions,
// Z-select encodings and the saturation clamp generator.
package dsp_pkg;

   localparam int OP_PREADD_EN = 0;
   localparam int OP_PRESUB    = 1;
   localparam int OP_ZSEL_LO   = 2;
   localparam int OP_ZSEL_HI   = 3;
   localparam int OP_POSTSUB   = 4;
   localparam int OP_CIN_EN    = 5;

   localparam logic [1:0] ZSEL_ZERO = 2'b00;
   localparam logic [1:0] ZSEL_C    = 2'b01;
   localparam logic [1:0] ZSEL_PCIN = 2'b10;
   localparam logic [1:0] ZSEL_P    = 2'b11;

   localparam int SAT_MAXW = 128;

   // Largest positive or most negative signed value of a pw-bit word; callers keep the low pw bits.
   function automatic logic [SAT_MAXW-1:0] sat_pw(input logic neg, input int pw);
      logic [SAT_MAXW-1:0] pos_v;
      pos_v = (128'd1 << (pw - 1)) - 128'd1;
      if (neg) begin
         sat_pw = ~pos_v;
      end else begin
         sat_pw = pos_v;
      end
   endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Valid-tracked delay line of 0..2 stages. Data only moves behind a valid beat,
// so bubbles never overwrite the operands parked in a stage.
module dsp_pipe_reg
   import dsp_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce,
   input  logic         vin,
   input  logic [W-1:0] din,
   output logic         vout,
   output logic [W-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign vout = vin;
         assign dout = din;
      end else begin : g_stages
         logic [W-1:0]     data_r [DEPTH];
         logic [DEPTH-1:0] valid_r;

         // Stage registers: valid bits advance on every enabled cycle, data only behind a valid beat.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_r <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  data_r[i] <= '0;
               end
            end else if (ce) begin
               valid_r[0] <= vin;
               if (vin) begin
                  data_r[0] <= din;
               end
               for (int i = 1; i < DEPTH; i++) begin
                  valid_r[i] <= valid_r[i-1];
                  if (valid_r[i-1]) begin
                     data_r[i] <= data_r[i-1];
                  end
               end
            end
         end

         assign vout = valid_r[DEPTH-1];
         assign dout = data_r[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined pre-adder -> signed multiplier -> post-adder/accumulator slice with
// per-beat OPMODE, optional saturation and PCIN/PCOUT cascade.
module dsp_mac_pipe
   import dsp_pkg::*;
#(
   parameter int AW        = 18,
   parameter int BW        = 18,
   parameter int CW        = 48,
   parameter int PW        = 48,
   parameter int IN_STAGES = 1,
   parameter int MREG      = 1,
   parameter int SAT_EN    = 0
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            CE,
   input  logic            VALID_IN,
   input  logic [5:0]      OPMODE,
   input  logic [AW-1:0]   A,
   input  logic [BW-1:0]   B,
   input  logic [BW-1:0]   D,
   input  logic [CW-1:0]   C,
   input  logic [PW-1:0]   PCIN,
   input  logic            CARRYIN,
   output logic            VALID_OUT,
   output logic [AW+BW:0]  M,
   output logic [PW-1:0]   P,
   output logic [PW-1:0]   PCOUT,
   output logic            CARRYOUT,
   output logic            OVF
);

   localparam int MW = AW + BW + 1;
   localparam int IW = 7 + AW + 2 * BW + CW;
   localparam int KW = 5 + CW + MW;

   logic [IW-1:0]  s1_data_s;
   logic           s1_valid_s;
   logic [5:0]     s1_op_s;
   logic           s1_cin_s;
   logic [AW-1:0]  s1_a_s;
   logic [BW-1:0]  s1_b_s;
   logic [BW-1:0]  s1_d_s;
   logic [CW-1:0]  s1_c_s;
   logic [BW:0]    pre_s;
   logic [MW-1:0]  prod_s;

   logic [KW-1:0]  s2_data_s;
   logic           s2_valid_s;
   logic           s2_cinen_s;
   logic           s2_postsub_s;
   logic [1:0]     s2_zsel_s;
   logic           s2_cin_s;
   logic [CW-1:0]  s2_c_s;
   logic [MW-1:0]  s2_m_s;

   logic [PW-1:0]  z_s;
   logic [PW-1:0]  mx_s;
   logic           cin_s;
   logic [PW:0]    tru_s;
   logic [PW-1:0]  res_s;
   logic           carry_s;
   logic           ovf_s;

   logic [PW-1:0]  p_r;
   logic           carry_r;
   logic           ovf_r;
   logic           valid_out_r;

   dsp_pipe_reg #(.W(IW), .DEPTH(IN_STAGES)) u_in_pipe (
      .clk   (CLK),
      .rst_n (RST_N),
      .ce    (CE),
      .vin   (VALID_IN),
      .din   ({OPMODE, CARRYIN, A, B, D, C}),
      .vout  (s1_valid_s),
      .dout  (s1_data_s)
   );

   assign {s1_op_s, s1_cin_s, s1_a_s, s1_b_s, s1_d_s, s1_c_s} = s1_data_s;

   // Pre-adder, sign-extended to BW+1 bits so D+B and D-B never wrap.
   always_comb begin
      pre_s = {s1_b_s[BW-1], s1_b_s};
      if (!s1_op_s[OP_PREADD_EN]) begin
         pre_s = {s1_b_s[BW-1], s1_b_s};
      end else if (s1_op_s[OP_PRESUB]) begin
         pre_s = {s1_d_s[BW-1], s1_d_s} - {s1_b_s[BW-1], s1_b_s};
      end else begin
         pre_s = {s1_d_s[BW-1], s1_d_s} + {s1_b_s[BW-1], s1_b_s};
      end
   end

   assign prod_s = MW'($signed(s1_a_s)) * MW'($signed(pre_s));

   dsp_pipe_reg #(.W(KW), .DEPTH(MREG)) u_m_pipe (
      .clk   (CLK),
      .rst_n (RST_N),
      .ce    (CE),
      .vin   (s1_valid_s),
      .din   ({s1_op_s[OP_CIN_EN], s1_op_s[OP_POSTSUB], s1_op_s[OP_ZSEL_HI:OP_ZSEL_LO],
               s1_cin_s, s1_c_s, prod_s}),
      .vout  (s2_valid_s),
      .dout  (s2_data_s)
   );

   assign {s2_cinen_s, s2_postsub_s, s2_zsel_s, s2_cin_s, s2_c_s, s2_m_s} = s2_data_s;
   assign mx_s  = PW'($signed(s2_m_s));
   assign cin_s = s2_cinen_s & s2_cin_s;

   // Z operand select; PCIN is taken live here so it aligns with an upstream PCOUT.
   always_comb begin
      z_s = '0;
      case (s2_zsel_s)
         ZSEL_ZERO: z_s = '0;
         ZSEL_C:    z_s = PW'($signed(s2_c_s));
         ZSEL_PCIN: z_s = PCIN;
         ZSEL_P:    z_s = p_r;
         default:   z_s = '0;
      endcase
   end

   // Post-adder in PW+1 signed bits. The unsigned carry/borrow out of bit PW-1 is recovered
   // from the extra sign bit: it equals tru[PW] ^ z[PW-1] ^ mx[PW-1] for both add and subtract.
   always_comb begin
      tru_s = '0;
      if (s2_postsub_s) begin
         tru_s = {z_s[PW-1], z_s} - {mx_s[PW-1], mx_s} - {{PW{1'b0}}, cin_s};
      end else begin
         tru_s = {z_s[PW-1], z_s} + {mx_s[PW-1], mx_s} + {{PW{1'b0}}, cin_s};
      end
      carry_s = tru_s[PW] ^ z_s[PW-1] ^ mx_s[PW-1];
      ovf_s   = tru_s[PW] ^ tru_s[PW-1];
      if ((SAT_EN != 0) && ovf_s) begin
         res_s = PW'(sat_pw(tru_s[PW], PW));
      end else begin
         res_s = tru_s[PW-1:0];
      end
   end

   // Result register: only a valid final-stage beat updates P, so accumulation holds across bubbles.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         p_r         <= '0;
         carry_r     <= 1'b0;
         ovf_r       <= 1'b0;
         valid_out_r <= 1'b0;
      end else if (CE) begin
         valid_out_r <= s2_valid_s;
         if (s2_valid_s) begin
            p_r     <= res_s;
            carry_r <= carry_s;
            ovf_r   <= ovf_s;
         end
      end
   end

   assign M         = s2_m_s;
   assign P         = p_r;
   assign PCOUT     = p_r;
   assign CARRYOUT  = carry_r;
   assign OVF       = ovf_r;
   assign VALID_OUT = valid_out_r;

endmodule
